// File: rtl/core2wb_pipe.sv
// core2wb_pipe: pipelined bridge from an Ibex-style req/gnt/rvalid port to a
// Wishbone B4 pipelined master. Tracks up to MAX_OUTSTANDING granted but
// unacknowledged transfers, optionally registers the response, and aborts a
// hung bus cycle via an ack watchdog, answering every stranded grant with an
// error response so the core always sees exactly one response per grant.
module core2wb_pipe #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RESP_REG        = 0,
    parameter int TIMEOUT         = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    // core side
    input  logic                core_req,
    output logic                core_gnt,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic                core_we,
    input  logic [DATA_W/8-1:0] core_be,
    input  logic [DATA_W-1:0]   core_wdata,
    output logic                core_rvalid,
    output logic [DATA_W-1:0]   core_rdata,
    output logic                core_err,
    // wishbone side
    output logic                wb_cyc,
    output logic                wb_stb,
    output logic [ADDR_W-1:0]   wb_adr,
    output logic                wb_we,
    output logic [DATA_W/8-1:0] wb_sel,
    output logic [DATA_W-1:0]   wb_dat_m,
    input  logic [DATA_W-1:0]   wb_dat_s,
    input  logic                wb_ack,
    input  logic                wb_err,
    input  logic                wb_stall
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CTR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // IDLE and RUN both accept requests; RUN just marks an open bus cycle.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ABORT = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   pend, pend_nxt;
    logic [CTR_W-1:0]   ctr, ctr_nxt;

    logic               run_en;
    logic               stb_i, gnt_i, cyc_i;
    logic               bus_resp;
    logic               resp_hit;
    logic               timeout_hit;

    logic               rv_c, err_c;
    logic [DATA_W-1:0]  rdata_c;
    logic               rv_q, err_q;
    logic [DATA_W-1:0]  rdata_q;

    logic               rv_o, err_o;
    logic [DATA_W-1:0]  rdata_o;

    // Request path and response qualification. Kept free of rst_n so the
    // reset net only reaches flop reset pins; outputs are gated separately.
    always_comb begin
        run_en   = (state == S_IDLE) || (state == S_RUN);
        stb_i    = run_en && core_req && (cnt < CNT_W'(MAX_OUTSTANDING));
        gnt_i    = stb_i && !wb_stall;
        cyc_i    = run_en && (stb_i || (cnt != '0));
        bus_resp = wb_ack || wb_err;
        // A response with nothing outstanding and nothing granted is stray.
        resp_hit = cyc_i && bus_resp && ((cnt != '0) || gnt_i);
    end

    // Watchdog trip: ctr has already counted TIMEOUT-1 silent cycles and
    // this cycle is silent too.
    always_comb begin
        timeout_hit = 1'b0;
        if (TIMEOUT != 0 && run_en && cnt != '0 && !bus_resp)
            timeout_hit = (ctr == CTR_W'(TIMEOUT - 1));
    end

    // Unregistered response: bus ack/err in RUN, synthetic errors in DRAIN.
    always_comb begin
        rv_c    = 1'b0;
        err_c   = 1'b0;
        rdata_c = '0;
        if (resp_hit) begin
            rv_c = 1'b1;
            if (wb_err) err_c = 1'b1;
            else        rdata_c = wb_dat_s;
        end else if (state == S_DRAIN) begin
            rv_c  = 1'b1;
            err_c = 1'b1;
        end
    end

    // Next-state logic for FSM, outstanding counter, drain counter, watchdog.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        ctr_nxt   = ctr;
        case (state)
            S_IDLE, S_RUN: begin
                cnt_nxt = cnt + CNT_W'(gnt_i) - CNT_W'(resp_hit);
                if (TIMEOUT == 0 || bus_resp || cnt == '0)
                    ctr_nxt = '0;
                else
                    ctr_nxt = ctr + CTR_W'(1);
                if (timeout_hit)
                    state_nxt = S_ABORT;
                else
                    state_nxt = cyc_i ? S_RUN : S_IDLE;
            end
            S_ABORT: begin
                // Bus is dropped; whatever was still in flight gets an error.
                pend_nxt  = cnt;
                cnt_nxt   = '0;
                ctr_nxt   = '0;
                state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                pend_nxt = pend - CNT_W'(1);
                if (pend <= CNT_W'(1))
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            pend  <= '0;
            ctr   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            ctr   <= ctr_nxt;
        end
    end

    // Optional one-cycle response register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            rv_q    <= rv_c;
            err_q   <= err_c;
            rdata_q <= rdata_c;
        end
    end

    // Output selection; rst_n forces every output low immediately.
    always_comb begin
        rv_o    = (RESP_REG != 0) ? rv_q    : rv_c;
        err_o   = (RESP_REG != 0) ? err_q   : err_c;
        rdata_o = (RESP_REG != 0) ? rdata_q : rdata_c;

        core_gnt    = rst_n && gnt_i;
        core_rvalid = rst_n && rv_o;
        core_err    = rst_n && rv_o && err_o;
        core_rdata  = (rst_n && rv_o) ? rdata_o : '0;

        wb_cyc   = rst_n && cyc_i;
        wb_stb   = rst_n && stb_i;
        wb_adr   = (rst_n && stb_i) ? core_addr  : '0;
        wb_we    = rst_n && stb_i && core_we;
        wb_sel   = (rst_n && stb_i) ? core_be    : SEL_W'(0);
        wb_dat_m = (rst_n && stb_i) ? core_wdata : '0;
    end

endmodule

// File: tb/tb_core2wb_pipe.sv
// Testbench for core2wb_pipe. Two instances share all stimulus: dut_a has a
// combinational response, dut_b a registered one; both use TIMEOUT=8.
// A scoreboard queue per instance holds expected responses in order.
module tb_core2wb_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic [31:0] dat_s = '0;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic        stall = 1'b0;

    logic        gnt_a, rvalid_a, err_a, cyc_a, stb_a, we_a;
    logic [31:0] rdata_a, adr_a, dat_m_a;
    logic [3:0]  sel_a;
    logic        gnt_b, rvalid_b, err_b, cyc_b, stb_b, we_b;
    logic [31:0] rdata_b, adr_b, dat_m_b;
    logic [3:0]  sel_b;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t q_a[$];
    resp_t q_b[$];
    resp_t e_a, e_b;

    always #5 clk = ~clk;

    core2wb_pipe #(.RESP_REG(0), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .core_req(req), .core_gnt(gnt_a), .core_addr(addr), .core_we(we),
        .core_be(be), .core_wdata(wdata), .core_rvalid(rvalid_a),
        .core_rdata(rdata_a), .core_err(err_a),
        .wb_cyc(cyc_a), .wb_stb(stb_a), .wb_adr(adr_a), .wb_we(we_a),
        .wb_sel(sel_a), .wb_dat_m(dat_m_a), .wb_dat_s(dat_s),
        .wb_ack(ack), .wb_err(err), .wb_stall(stall)
    );

    core2wb_pipe #(.RESP_REG(1), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .core_req(req), .core_gnt(gnt_b), .core_addr(addr), .core_we(we),
        .core_be(be), .core_wdata(wdata), .core_rvalid(rvalid_b),
        .core_rdata(rdata_b), .core_err(err_b),
        .wb_cyc(cyc_b), .wb_stb(stb_b), .wb_adr(adr_b), .wb_we(we_b),
        .wb_sel(sel_b), .wb_dat_m(dat_m_b), .wb_dat_s(dat_s),
        .wb_ack(ack), .wb_err(err), .wb_stall(stall)
    );

    logic [105:0] outs_a, outs_b;
    assign outs_a = {gnt_a, rvalid_a, err_a, rdata_a, cyc_a, stb_a, adr_a, we_a, sel_a, dat_m_a};
    assign outs_b = {gnt_b, rvalid_b, err_b, rdata_b, cyc_b, stb_b, adr_b, we_b, sel_b, dat_m_b};

    // Scoreboard monitors: every rvalid must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n && rvalid_a) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL resp_a_unexpected: rvalid err=%0b rdata=%h, required no response", err_a, rdata_a);
            end else begin
                e_a = q_a.pop_front();
                if ({err_a, rdata_a} !== {e_a.err, e_a.data}) begin
                    errors++;
                    $display("FAIL resp_a: err=%0b rdata=%h, required err=%0b rdata=%h",
                             err_a, rdata_a, e_a.err, e_a.data);
                end
            end
        end
        if (rst_n && rvalid_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL resp_b_unexpected: rvalid err=%0b rdata=%h, required no response", err_b, rdata_b);
            end else begin
                e_b = q_b.pop_front();
                if ({err_b, rdata_b} !== {e_b.err, e_b.data}) begin
                    errors++;
                    $display("FAIL resp_b: err=%0b rdata=%h, required err=%0b rdata=%h",
                             err_b, rdata_b, e_b.err, e_b.data);
                end
            end
        end
    end

    task automatic expect_resp(input logic e, input logic [31:0] d);
        resp_t r;
        r.err  = e;
        r.data = d;
        q_a.push_back(r);
        q_b.push_back(r);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 1'b1;
        addr  = 32'h1234_5678;
        we    = 1'b1;
        be    = 4'hF;
        wdata = 32'h5555_AAAA;
        ack   = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (outs_a !== '0) begin
            errors++;
            $display("FAIL reset_outs_a: %h, required 0", outs_a);
        end
        checks++;
        if (outs_b !== '0) begin
            errors++;
            $display("FAIL reset_outs_b: %h, required 0", outs_b);
        end
        req = 1'b0; we = 1'b0; ack = 1'b0; addr = '0; wdata = '0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cyc_a !== 1'b0 || stb_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: cyc=%0b stb=%0b, required 0 0", cyc_a, stb_a);
        end
    endtask

    task automatic test_single_read();
        next_cycle();
        req = 1'b1; we = 1'b0; addr = 32'h0000_1000; be = 4'hF;
        @(negedge clk);
        checks++;
        if ({gnt_a, stb_a, cyc_a, adr_a} !== {3'b111, 32'h0000_1000}) begin
            errors++;
            $display("FAIL single_req: gnt=%0b stb=%0b cyc=%0b adr=%h, required 1 1 1 00001000",
                     gnt_a, stb_a, cyc_a, adr_a);
        end
        next_cycle();
        req = 1'b0; ack = 1'b1; dat_s = 32'hDEAD_BEEF;
        expect_resp(1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (rvalid_a !== 1'b1 || rvalid_b !== 1'b0) begin
            errors++;
            $display("FAIL single_lat1: rvalid_a=%0b rvalid_b=%0b, required 1 0", rvalid_a, rvalid_b);
        end
        next_cycle();
        ack = 1'b0; dat_s = '0;
        @(negedge clk);
        checks++;
        if (rvalid_a !== 1'b0 || rvalid_b !== 1'b1 || rdata_b !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_lat2: rvalid_a=%0b rvalid_b=%0b rdata_b=%h, required 0 1 deadbeef",
                     rvalid_a, rvalid_b, rdata_b);
        end
        checks++;
        if (cyc_a !== 1'b0) begin
            errors++;
            $display("FAIL single_cyc_drop: cyc=%0b, required 0", cyc_a);
        end
    endtask

    task automatic test_back_to_back();
        int ng = 0;
        int na = 0;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            req  = (ng < 5);
            addr = 32'h0000_2000 + 32'(ng * 4);
            we   = 1'b0;
            if (c >= 4 && na < ng) begin
                ack   = 1'b1;
                dat_s = 32'hA000_0000 + 32'(na);
                expect_resp(1'b0, dat_s);
                na++;
            end else begin
                ack = 1'b0;
            end
            @(negedge clk);
            if (c == 4) begin
                checks++;
                if ({stb_a, gnt_a, cyc_a} !== 3'b001) begin
                    errors++;
                    $display("FAIL b2b_full: stb=%0b gnt=%0b cyc=%0b, required 0 0 1", stb_a, gnt_a, cyc_a);
                end
            end
            if (c == 9) begin
                checks++;
                if (cyc_a !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_cyc_drop: cyc=%0b, required 0", cyc_a);
                end
            end
            if (gnt_a === 1'b1) ng++;
        end
        checks++;
        if (ng != 5) begin
            errors++;
            $display("FAIL b2b_grants: %0d, required 5", ng);
        end
        ack = 1'b0;
    endtask

    task automatic test_stall_write();
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            req = 1'b1; we = 1'b1; addr = 32'h0000_3000; be = 4'b0110;
            wdata = 32'hCAFE_F00D; stall = (c < 3);
            @(negedge clk);
            checks++;
            if ({stb_a, cyc_a, we_a, adr_a, sel_a, dat_m_a} !==
                {3'b111, 32'h0000_3000, 4'b0110, 32'hCAFE_F00D}) begin
                errors++;
                $display("FAIL stall_hold c%0d: stb=%0b cyc=%0b we=%0b adr=%h sel=%h dat=%h, required 1 1 1 00003000 6 cafef00d",
                         c, stb_a, cyc_a, we_a, adr_a, sel_a, dat_m_a);
            end
            checks++;
            if (gnt_a !== (c == 3)) begin
                errors++;
                $display("FAIL stall_gnt c%0d: gnt=%0b, required %0b", c, gnt_a, (c == 3));
            end
        end
        next_cycle();
        req = 1'b0; we = 1'b0; stall = 1'b0; ack = 1'b1; dat_s = '0;
        expect_resp(1'b0, 32'h0);
        @(negedge clk);
        next_cycle();
        ack = 1'b0;
        @(negedge clk);
        checks++;
        if (cyc_a !== 1'b0) begin
            errors++;
            $display("FAIL stall_cyc_drop: cyc=%0b, required 0", cyc_a);
        end
    endtask

    task automatic test_err_mid();
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            req  = (c < 3);
            addr = 32'h0000_4000 + 32'(c * 4);
            ack  = (c == 1) || (c == 3);
            err  = (c == 2);
            case (c)
                1: dat_s = 32'hB000_0000;
                2: dat_s = 32'hFFFF_FFFF;
                3: dat_s = 32'hB000_0002;
                default: dat_s = '0;
            endcase
            if (c == 1) expect_resp(1'b0, 32'hB000_0000);
            if (c == 2) expect_resp(1'b1, 32'h0);
            if (c == 3) expect_resp(1'b0, 32'hB000_0002);
            @(negedge clk);
            if (c < 3) begin
                checks++;
                if (gnt_a !== 1'b1) begin
                    errors++;
                    $display("FAIL err_gnt c%0d: gnt=%0b, required 1", c, gnt_a);
                end
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (cyc_a !== (c == 3)) begin
                    errors++;
                    $display("FAIL err_cyc c%0d: cyc=%0b, required %0b", c, cyc_a, (c == 3));
                end
            end
        end
        ack = 1'b0; err = 1'b0;
    endtask

    // Grants in c0/c1; outstanding from c1, watchdog counts 8 silent cycles
    // (c1..c8) so ABORT is c9, DRAIN c10..c11, requests accepted again at c12.
    task automatic test_timeout();
        expect_resp(1'b1, 32'h0);
        expect_resp(1'b1, 32'h0);
        for (int c = 0; c < 15; c++) begin
            next_cycle();
            req   = (c < 2) || (c >= 9 && c <= 12);
            addr  = (c < 2) ? 32'h0000_5000 + 32'(c * 4) : 32'h0000_5100;
            ack   = (c == 9) || (c == 13);
            dat_s = (c == 13) ? 32'h5A5A_5A5A : 32'h0;
            if (c == 13) expect_resp(1'b0, 32'h5A5A_5A5A);
            @(negedge clk);
            if (c == 8) begin
                checks++;
                if (cyc_a !== 1'b1) begin
                    errors++;
                    $display("FAIL to_before: cyc=%0b, required 1", cyc_a);
                end
            end
            if (c == 9) begin
                checks++;
                if ({cyc_a, stb_a, gnt_a, rvalid_a} !== 4'b0000) begin
                    errors++;
                    $display("FAIL to_abort: cyc=%0b stb=%0b gnt=%0b rvalid=%0b, required 0 0 0 0",
                             cyc_a, stb_a, gnt_a, rvalid_a);
                end
            end
            if (c == 10 || c == 11) begin
                checks++;
                if ({cyc_a, gnt_a, rvalid_a, err_a} !== 4'b0011) begin
                    errors++;
                    $display("FAIL to_drain c%0d: cyc=%0b gnt=%0b rvalid=%0b err=%0b, required 0 0 1 1",
                             c, cyc_a, gnt_a, rvalid_a, err_a);
                end
            end
            if (c == 12) begin
                checks++;
                if ({gnt_a, rvalid_a} !== 2'b10) begin
                    errors++;
                    $display("FAIL to_resume: gnt=%0b rvalid=%0b, required 1 0", gnt_a, rvalid_a);
                end
            end
            if (c == 14) begin
                checks++;
                if (cyc_a !== 1'b0) begin
                    errors++;
                    $display("FAIL to_end_cyc: cyc=%0b, required 0", cyc_a);
                end
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            req = 1'b1; addr = 32'h0000_6000 + 32'(c * 4);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs_a !== '0 || outs_b !== '0) begin
            errors++;
            $display("FAIL rstmid_outs: a=%h b=%h, required 0", outs_a, outs_b);
        end
        req = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cyc_a !== 1'b0 || cyc_b !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_cnt: cyc_a=%0b cyc_b=%0b, required 0 0", cyc_a, cyc_b);
        end
        next_cycle();
        req = 1'b1; addr = 32'h0000_7000;
        next_cycle();
        req = 1'b0; ack = 1'b1; dat_s = 32'h1357_9BDF;
        expect_resp(1'b0, 32'h1357_9BDF);
        next_cycle();
        ack = 1'b0;
        @(negedge clk);
        checks++;
        if (cyc_a !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: cyc=%0b, required 0", cyc_a);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_stall_write();
        test_err_mid();
        test_timeout();
        test_reset_mid();
        repeat (3) next_cycle();
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: a=%0d b=%0d responses missing, required 0 0", q_a.size(), q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
